ser_tx_arb: RTL and testbench



---
 rtl/ser_pkg.sv | 11 +
 rtl/ser_rr_pick.sv | 25 ++
 rtl/ser_tx_arb.sv | 179 +++++++++++++++++
 tb/tb_ser_tx_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types for the serial transmit path: arbiter state encoding and byte width.
package ser_pkg;

    localparam int SER_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } t_arb_state;

endpackage

// File: rtl/ser_rr_pick.sv
// Rotating-priority search: first set bit of req_i starting at ptr_i, wrapping modulo N.
// Purely combinational so any shared-resource arbiter can reuse it.
module ser_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    // Walk from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                hit_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ser_tx_arb.sv
// Message-granular round-robin arbiter sharing one UART TX core between N_REQ byte streams.
// Optional grant revocation on a stalled owner is built when SER_TX_ARB_TIMEOUT_EN is defined.
//
// Handshakes (requester side and UART side) are strict valid/ready: a byte moves on the
// rising edge where valid&ready is high; valid never waits on ready, and a presented
// byte is held stable until it is taken.
module ser_tx_arb
    import ser_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 2000000,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                        clk_50m,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [SER_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        tx_valid,
    output logic [SER_BYTE_W-1:0]       tx_data,
    input  logic                        tx_ready,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        timeout_evt,
    output t_arb_state                  dbg_state_o,
    output logic [IDX_W-1:0]            dbg_rr_ptr_o
);

    t_arb_state            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [SER_BYTE_W-1:0] tx_data_q, tx_data_d;

    logic                  pick_hit;
    logic [IDX_W-1:0]      pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [SER_BYTE_W-1:0] sel_data;
    logic                  slot_free;
    logic                  accept;
    logic [IDX_W-1:0]      next_ptr;

    ser_rr_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*SER_BYTE_W +: SER_BYTE_W];
            end
        end
    end

    // The output register can take a byte when empty or when it is being drained this cycle.
    assign slot_free = !tx_valid_q || tx_ready;
    assign accept    = (state_q == GRANT) && sel_valid && slot_free;
    assign next_ptr  = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);

`ifdef SER_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_evt_q, timeout_evt_d;
    logic             owner_idle;
    logic             timeout_hit;

    // Only an owner with nothing to offer is charged; UART backpressure is not its fault.
    assign owner_idle  = (state_q == GRANT) && !sel_valid;
    assign timeout_hit = owner_idle && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != GRANT || accept) begin
            cnt_d = '0;
        end else if (owner_idle) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign timeout_evt = timeout_evt_q;
`else
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
`ifdef SER_TX_ARB_TIMEOUT_EN
        timeout_evt_d = 1'b0;
`endif

        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    state_d     = GRANT;
                    grant_idx_d = pick_idx;
                end
            end
            GRANT: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
`ifdef SER_TX_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rr_ptr_d      = next_ptr;
                    timeout_evt_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        grant_valid = (state_q == GRANT);
        if (state_q == GRANT) begin
            req_ready[grant_idx_q] = slot_free;
        end
    end

    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign grant_idx    = grant_idx_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_ser_tx_arb.sv
// Directed bench for ser_tx_arb with two requesters; timeout step adapts to SER_TX_ARB_TIMEOUT_EN.
module tb_ser_tx_arb;
    import ser_pkg::*;

    localparam int N_REQ = 2;
    localparam int TO    = 100;

    logic             clk_50m = 1'b0;
    logic             rst     = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [15:0]      req_data  = '0;
    logic [1:0]       req_last  = '0;
    logic [1:0]       req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready = 1'b0;
    logic             grant_valid;
    logic [0:0]       grant_idx;
    logic             timeout_evt;
    t_arb_state       dbg_state;
    logic [0:0]       dbg_rr_ptr;

    int total = 0;
    int bad   = 0;
    int evt_cnt = 0;
    int k;

    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [0:0] gnt_q[$];
    logic       gv_prev = 1'b0;

    ser_tx_arb #(.N_REQ(N_REQ), .TIMEOUT_CYC(TO)) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .timeout_evt  (timeout_evt),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr_ptr)
    );

    always #10 clk_50m = ~clk_50m;

    // UART-side monitor: bytes taken, grant starts, timeout pulses.
    always @(posedge clk_50m) begin
        if (rst) begin
            gv_prev <= 1'b0;
        end else begin
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (grant_valid && !gv_prev) gnt_q.push_back(grant_idx);
            if (timeout_evt) evt_cnt++;
            gv_prev <= grant_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid[0]   = (rq0.size() != 0);
        req_data[7:0]  = (rq0.size() != 0) ? rq0[0][7:0] : 8'h00;
        req_last[0]    = (rq0.size() != 0) ? rq0[0][8] : 1'b0;
        req_valid[1]   = (rq1.size() != 0);
        req_data[15:8] = (rq1.size() != 0) ? rq1[0][7:0] : 8'h00;
        req_last[1]    = (rq1.size() != 0) ? rq1[0][8] : 1'b0;
    endtask

    // Ends 2 time units after the edge with inputs updated and combinational outputs settled.
    task automatic tick();
        logic [1:0] pop;
        pop = req_valid & req_ready;
        @(posedge clk_50m);
        #1;
        if (pop[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (pop[1] && rq1.size() != 0) void'(rq1.pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset();
        rq0.delete();
        rq1.delete();
        tx_ready = 1'b0;
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        gnt_q.delete();
        evt_cnt = 0;
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hdead, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        // Reset state
        drive();
        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_timeout_evt", timeout_evt, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_rr_ptr", dbg_rr_ptr, 0);

        // Single message "A\r" from requester 0, tx_ready pulsed every 10 cycles
        do_reset();
        rq0.push_back({1'b0, 8'h41});
        rq0.push_back({1'b1, 8'h0D});
        drive();
        #1;
        check("t1_idle_ready", req_ready, 2'b00);
        tick();
        check("t1_gv", grant_valid, 1);
        check("t1_gidx", grant_idx, 0);
        check("t1_ready", req_ready, 2'b01);
        check("t1_txv_pre", tx_valid, 0);
        tick();
        check("t1_txv", tx_valid, 1);
        check("t1_txd", tx_data, 8'h41);
        check("t1_ready_full", req_ready, 2'b00);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t1_hold", tx_data, 8'h41);
        end
        tx_ready = 1'b1;
        #1;
        check("t1_ready_drain", req_ready, 2'b01);
        tick();
        tx_ready = 1'b0;
        check("t1_txd2", tx_data, 8'h0D);
        check("t1_txv2", tx_valid, 1);
        check("t1_gv_fall", grant_valid, 0);
        check("t1_rr", dbg_rr_ptr, 1);
        check("t1_state", dbg_state, IDLE);
        for (int i = 0; i < 9; i++) tick();
        tx_ready = 1'b1;
        #1;
        tick();
        tx_ready = 1'b0;
        check("t1_txv_drop", tx_valid, 0);
        exp_q = '{8'h41, 8'h0D};
        cmp_stream("t1_stream");

        // Contention: "Ish" from 0 and "bel" from 1, both pending from reset
        do_reset();
        rq0 = '{{1'b0, 8'h49}, {1'b0, 8'h73}, {1'b1, 8'h68}};
        rq1 = '{{1'b0, 8'h62}, {1'b0, 8'h65}, {1'b1, 8'h6C}};
        tx_ready = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 60; i++) begin
            if (got_q.size() >= 6) break;
            tick();
        end
        exp_q = '{8'h49, 8'h73, 8'h68, 8'h62, 8'h65, 8'h6C};
        cmp_stream("t2_stream");
        check("t2_ngrants", gnt_q.size(), 2);
        check("t2_g0", (gnt_q.size() > 0) ? gnt_q[0] : 1'bx, 0);
        check("t2_g1", (gnt_q.size() > 1) ? gnt_q[1] : 1'bx, 1);

        // Round-robin fairness: 4 single-byte messages per requester
        do_reset();
        rq0 = '{{1'b1, 8'h10}, {1'b1, 8'h11}, {1'b1, 8'h12}, {1'b1, 8'h13}};
        rq1 = '{{1'b1, 8'h20}, {1'b1, 8'h21}, {1'b1, 8'h22}, {1'b1, 8'h23}};
        tx_ready = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 100; i++) begin
            if (got_q.size() >= 8) break;
            tick();
        end
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        cmp_stream("t3_stream");
        check("t3_ngrants", gnt_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_alt", (i < gnt_q.size()) ? gnt_q[i] : 1'bx, i % 2);
        end

        // Backpressure: tx_ready low for 50 cycles with a byte pending
        do_reset();
        rq0 = '{{1'b0, 8'hA5}, {1'b0, 8'h5A}, {1'b1, 8'hFF}};
        drive();
        #1;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) break;
            tick();
        end
        check("t4_txv_up", tx_valid, 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("t4_hold_d", tx_data, 8'hA5);
            check("t4_hold_v", tx_valid, 1);
            check("t4_ready0", req_ready, 2'b00);
        end
        check("t4_pending", rq0.size(), 2);
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (got_q.size() >= 3) break;
            tick();
        end
        exp_q = '{8'hA5, 8'h5A, 8'hFF};
        cmp_stream("t4_stream");
        check("t4_gv_end", grant_valid, 0);

        // Timeout: requester 0 stalls mid-message while requester 1 waits
        do_reset();
        rq0 = '{{1'b0, 8'h77}};
        rq1 = '{{1'b1, 8'h88}};
        tx_ready = 1'b1;
        drive();
        #1;
        tick();
        check("t5_gidx0", grant_idx, 0);
        tick();
        check("t5_txd", tx_data, 8'h77);
`ifdef SER_TX_ARB_TIMEOUT_EN
        k = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            k++;
            if (timeout_evt) break;
        end
        check("t5_evt_at", k, TO);
        check("t5_evt", timeout_evt, 1);
        check("t5_gv_drop", grant_valid, 0);
        tick();
        check("t5_evt_pulse", timeout_evt, 0);
        check("t5_gv_new", grant_valid, 1);
        check("t5_gidx_new", grant_idx, 1);
        tick();
        tick();
        check("t5_evt_cnt", evt_cnt, 1);
        exp_q = '{8'h77, 8'h88};
        cmp_stream("t5_stream");
`else
        for (int i = 0; i < 300; i++) tick();
        check("t5_gv_held", grant_valid, 1);
        check("t5_gidx_held", grant_idx, 0);
        check("t5_no_evt", evt_cnt, 0);
        check("t5_ngrants", gnt_q.size(), 1);
        check("t5_r1_waiting", rq1.size(), 1);
`endif

        // Reset mid-message
        do_reset();
        rq0 = '{{1'b1, 8'h55}};
        tx_ready = 1'b1;
        drive();
        #1;
        tick();
        tick();
        check("t6_rr1", dbg_rr_ptr, 1);
        rq1 = '{{1'b0, 8'h61}, {1'b0, 8'h62}, {1'b1, 8'h63}};
        drive();
        #1;
        tick();
        tick();
        tx_ready = 1'b0;
        check("t6_txv", tx_valid, 1);
        check("t6_txd", tx_data, 8'h61);
        check("t6_gv", grant_valid, 1);
        check("t6_gidx", grant_idx, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_txv", tx_valid, 0);
        check("t6_rst_txd", tx_data, 8'h00);
        check("t6_rst_gv", grant_valid, 0);
        check("t6_rst_rr", dbg_rr_ptr, 0);
        check("t6_rst_state", dbg_state, IDLE);
        check("t6_rst_ready", req_ready, 2'b00);
        rst = 1'b0;
        rq0.delete();
        rq1.delete();
        drive();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
